// File: rtl/div32by16_seq.sv
// Sequential 32/16 unsigned restoring divider: one quotient bit per clock, 16 RUN cycles.
// Divide-by-zero and quotient overflow are reported immediately via err.
module div32by16_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] dividend,
    input  logic [15:0] divisor,
    output logic        busy,
    output logic        done,
    output logic [15:0] quotient,
    output logic [15:0] remainder,
    output logic        err
);
    localparam int unsigned DW = 16;
    localparam int unsigned RW = DW + 1;
    localparam int unsigned CW = 4;
    localparam logic [CW-1:0] LAST = CW'(DW - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [DW-1:0] r_q;
    logic [DW-1:0] q_q;
    logic [DW-1:0] dvs_q;
    logic [CW-1:0] cnt_q;

    logic          accept_c;
    logic          bad_c;
    logic          last_c;
    logic [RW-1:0] shift_c;
    logic [RW-1:0] diff_c;
    logic          fits_c;
    logic [RW-1:0] r_next_c;
    logic [DW-1:0] q_next_c;
    logic          busy_nxt;
    logic          done_nxt;

    // Operand screening and accept qualification
    assign accept_c = (state == IDLE) && start;
    assign bad_c    = (divisor == '0) || (dividend[31:16] >= divisor);
    assign last_c   = (state == RUN) && (cnt_q == LAST);

    // One restoring step; the partial remainder never exceeds 16 bits after a step
    assign shift_c  = {r_q, q_q[DW-1]};
    assign diff_c   = shift_c - {1'b0, dvs_q};
    assign fits_c   = shift_c >= {1'b0, dvs_q};
    assign r_next_c = fits_c ? diff_c : shift_c;
    assign q_next_c = {q_q[DW-2:0], fits_c};

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = bad_c ? DONE : RUN;
                end
            end
            RUN: begin
                if (cnt_q == LAST) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode, registered below so busy/done track the state register exactly
    always_comb begin
        busy_nxt = 1'b0;
        done_nxt = 1'b0;
        case (state_nxt)
            RUN:     busy_nxt = 1'b1;
            DONE:    done_nxt = 1'b1;
            default: ;
        endcase
    end

    // Working registers: operands captured on accept, shifted once per RUN cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q   <= '0;
            q_q   <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
        end else if (accept_c) begin
            r_q   <= dividend[31:16];
            q_q   <= dividend[15:0];
            dvs_q <= divisor;
            cnt_q <= '0;
        end else if (state == RUN) begin
            r_q   <= DW'(r_next_c);
            q_q   <= q_next_c;
            cnt_q <= cnt_q + CW'(1);
        end
    end

    // Result registers change only when DONE is entered; err is cleared on a good accept
    always_ff @(posedge clk) begin
        if (rst) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            err       <= 1'b0;
        end else begin
            busy <= busy_nxt;
            done <= done_nxt;
            if (accept_c) begin
                if (bad_c) begin
                    err       <= 1'b1;
                    quotient  <= '1;
                    remainder <= '0;
                end else begin
                    err <= 1'b0;
                end
            end else if (last_c) begin
                quotient  <= q_next_c;
                remainder <= DW'(r_next_c);
            end
        end
    end

endmodule

// File: doc/div32by16_seq.md
DIV32BY16_SEQ -- requirements
Module: div32by16_seq

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset; there are no parameters, and all widths are fixed.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 start  input  1  request to divide; sampled only in IDLE.
REQ-005 dividend  input  32  unsigned dividend; the natural input is a 16x16 multiplier product.
REQ-006 divisor  input  16  unsigned divisor.
REQ-007 busy  output  1  high while the block is iterating (RUN).
REQ-008 done  output  1  one-cycle pulse: result valid.
REQ-009 quotient  output  16  unsigned quotient.
REQ-010 remainder  output  16  unsigned remainder.
REQ-011 err  output  1  high when the last operation was divide-by-zero or quotient overflow.

Function
REQ-012 The block SHALL implement the states IDLE, RUN and DONE, held in a registered state variable.
REQ-013 In IDLE with start=1, the block SHALL latch dividend and divisor on that edge, called the accept edge.
REQ-014 On the accept edge, if divisor==0 or dividend[31:16] >= divisor, the block SHALL go IDLE->DONE and set err=1, quotient=16'hFFFF and remainder=16'h0000.
REQ-015 Otherwise, on the accept edge, the block SHALL go IDLE->RUN, clear the 4-bit iteration counter and set err=0.
REQ-016 Each RUN edge SHALL perform one restoring step using a 17-bit partial remainder: shift {R,Q} left by 1; if R >= divisor, subtract divisor and set the Q LSB to 1, else set it to 0.
REQ-017 RUN SHALL perform exactly 16 steps; on the edge that completes step 16 (counter==15), the block SHALL go RUN->DONE.
REQ-018 The first RUN step SHALL use the initial R = dividend[31:16] and the initial Q shift register = dividend[15:0].
REQ-019 DONE SHALL last exactly one cycle with done=1, then go to IDLE unconditionally.
REQ-020 Latency SHALL be as follows, counting the accept edge as edge 1:
  - normal operation: done is high after edge 17;
  - error operation: done is high after edge 1.
REQ-021 busy SHALL be 1 only in RUN.
REQ-022 start SHALL be ignored in RUN and DONE; a new start is accepted only in IDLE, so the earliest one is the cycle after done.
REQ-023 Changes on dividend or divisor after the accept edge SHALL NOT affect the operation in flight.
REQ-024 quotient, remainder and err SHALL hold their values from DONE through IDLE until the next accept edge.
REQ-025 quotient and remainder SHALL NOT change during RUN.
  - Internal working registers SHALL be separate from the output registers.
  - The output registers SHALL be updated only on the edge that enters DONE.
REQ-026 Every valid result SHALL satisfy quotient*divisor + remainder == dividend, with remainder < divisor.

Reset
REQ-027 While rst=1 at a rising edge, the block SHALL go to IDLE and drive busy=0, done=0, err=0, quotient=0 and remainder=0.
REQ-028 Reset SHALL take priority over start and over all state transitions.
REQ-029 Reset asserted mid-RUN SHALL abort the operation with no done pulse; the block SHALL accept start on the first edge after rst falls.

Verification
REQ-030 Basic division: dividend=32'd100, divisor=16'd7, start pulse. Required response: done after edge 17 with quotient=14, remainder=2, err=0; busy high for 16 cycles.
REQ-031 Maximum operands: dividend=32'hFFFE0001, divisor=16'hFFFF. Required response: quotient=16'hFFFF, remainder=0, err=0.
REQ-032 Error cases:
  - divisor=0 gives done after edge 1 with err=1 and quotient=16'hFFFF, remainder=0;
  - dividend=32'h00010000 with divisor=16'h0001 gives the same err response (overflow).
REQ-033 Start ignored while busy: pulse start with new operands at RUN step 5. Required response: the result still matches the first operands, and exactly one done pulse occurs.
REQ-034 Reset mid-operation: assert rst at RUN step 8. Required response:
  - all outputs are 0 and there is no done pulse;
  - a start issued immediately afterwards with 32'd1000/16'd10 gives quotient=100, remainder=0.
REQ-035 Round trip with the 16x16 multiplier: for 1000 random nonzero a, b, divide the product a*b by b. Required response: quotient==a, remainder==0, err=0.
